regfile_wb_queue: RTL and testbench

Writeback stage directly upstream of the 2-read/1-write register file. It accepts results from two producers (A: ALU, B: load unit) over valid/ready handshakes and buffers them in a small in-order FIFO. It drains one entry per cycle onto the register file write port. It also reports whether a write to a given register is still pending, so the operand-read logic can stall on hazards.

---
 rtl/regfile_wb_queue_if.sv | 41 ++++
 rtl/regfile_wb_queue.sv | 113 +++++++++++
 tb/tb_regfile_wb_queue.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_if.sv
// Bundle of the writeback queue's producer, register-file write and hazard-check signals.
// The slave modport is the queue side; the master modport drives it.
interface regfile_wb_queue_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 2,
    parameter int QDEPTH_LOG2 = 2
);
    logic                   in_a_valid;
    logic [DEPTH-1:0]       in_a_addr;
    logic [DATA_WIDTH-1:0]  in_a_data;
    logic                   out_a_ready;
    logic                   in_b_valid;
    logic [DEPTH-1:0]       in_b_addr;
    logic [DATA_WIDTH-1:0]  in_b_data;
    logic                   out_b_ready;
    logic                   in_drain_en;
    logic                   out_we;
    logic [DEPTH-1:0]       out_wr_addr;
    logic [DATA_WIDTH-1:0]  out_wr_data;
    logic [DEPTH-1:0]       in_chk_addr1;
    logic [DEPTH-1:0]       in_chk_addr2;
    logic                   out_pend1;
    logic                   out_pend2;
    logic [QDEPTH_LOG2:0]   out_count;

    modport slave (
        input  in_a_valid, in_a_addr, in_a_data,
        input  in_b_valid, in_b_addr, in_b_data,
        input  in_drain_en, in_chk_addr1, in_chk_addr2,
        output out_a_ready, out_b_ready, out_we, out_wr_addr, out_wr_data,
        output out_pend1, out_pend2, out_count
    );

    modport master (
        output in_a_valid, in_a_addr, in_a_data,
        output in_b_valid, in_b_addr, in_b_data,
        output in_drain_en, in_chk_addr1, in_chk_addr2,
        input  out_a_ready, out_b_ready, out_we, out_wr_addr, out_wr_data,
        input  out_pend1, out_pend2, out_count
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order writeback FIFO between two result producers and the register file write port.
// Round-robin arbitration on contention, r0 writes dropped, pending-write hazard lookup.
module regfile_wb_queue #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 2,
    parameter int QDEPTH_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_wb_queue_if.slave bus
);
    localparam int QN = 1 << QDEPTH_LOG2;
    localparam int PW = QDEPTH_LOG2;
    localparam int CW = QDEPTH_LOG2 + 1;

    logic [DEPTH-1:0]      addr_mem [QN];
    logic [DATA_WIDTH-1:0] data_mem [QN];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          favour_b_q, favour_b_d;

    logic                  full, empty;
    logic                  grant_a, grant_b;
    logic                  push, pop;
    logic [DEPTH-1:0]      push_addr;
    logic [DATA_WIDTH-1:0] push_data;
    logic [PW-1:0]         offset;
    logic                  pend1, pend2;

    assign full  = (count_q == CW'(QN));
    assign empty = (count_q == '0);

    // A full queue refuses both producers even when a pop happens in the same cycle.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!full) begin
            if (bus.in_a_valid && bus.in_b_valid) begin
                grant_a = !favour_b_q;
                grant_b = favour_b_q;
            end else begin
                grant_a = bus.in_a_valid;
                grant_b = bus.in_b_valid;
            end
        end
    end

    assign push_addr = grant_a ? bus.in_a_addr : bus.in_b_addr;
    assign push_data = grant_a ? bus.in_a_data : bus.in_b_data;
    assign push      = (grant_a || grant_b) && (push_addr != '0);
    assign pop       = !empty && bus.in_drain_en;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        favour_b_d = favour_b_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (!full && bus.in_a_valid && bus.in_b_valid)
            favour_b_d = grant_a;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            favour_b_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            favour_b_q <= favour_b_d;
        end
    end

    // Storage needs no reset: the occupancy count gates every use of it.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            addr_mem[wr_ptr_q] <= push_addr;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    // An entry is live when its distance from the head is below the occupancy count.
    always_comb begin
        pend1  = 1'b0;
        pend2  = 1'b0;
        offset = '0;
        for (int i = 0; i < QN; i++) begin
            offset = PW'(i) - rd_ptr_q;
            if ({1'b0, offset} < count_q) begin
                if (addr_mem[i] == bus.in_chk_addr1) pend1 = 1'b1;
                if (addr_mem[i] == bus.in_chk_addr2) pend2 = 1'b1;
            end
        end
    end

    assign bus.out_a_ready = grant_a;
    assign bus.out_b_ready = grant_b;
    assign bus.out_we      = pop;
    assign bus.out_wr_addr = empty ? '0 : addr_mem[rd_ptr_q];
    assign bus.out_wr_data = empty ? '0 : data_mem[rd_ptr_q];
    assign bus.out_pend1   = pend1 && (bus.in_chk_addr1 != '0);
    assign bus.out_pend2   = pend2 && (bus.in_chk_addr2 != '0);
    assign bus.out_count   = count_q;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios then random traffic against a queue-based model.
module tb_regfile_wb_queue;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int QL = 2;
    localparam int QCAP = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_wb_queue_if #(.DATA_WIDTH(DW), .DEPTH(AW), .QDEPTH_LOG2(QL)) bus ();

    regfile_wb_queue #(.DATA_WIDTH(DW), .DEPTH(AW), .QDEPTH_LOG2(QL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t model_q[$];
    bit   last_contention_winner_a;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        last_contention_winner_a = 1'b0;
    endtask

    // One clock: drive inputs, check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                         input bit drain, input logic [AW-1:0] c1, input logic [AW-1:0] c2);
        int   winner;
        bit   exp_we, exp_p1, exp_p2;
        ent_t head;
        bus.in_a_valid = av; bus.in_a_addr = aa; bus.in_a_data = ad;
        bus.in_b_valid = bv; bus.in_b_addr = ba; bus.in_b_data = bd;
        bus.in_drain_en = drain; bus.in_chk_addr1 = c1; bus.in_chk_addr2 = c2;
        @(negedge clk);
        winner = 0;
        if (model_q.size() < QCAP) begin
            if (av && bv) winner = last_contention_winner_a ? 2 : 1;
            else if (av)  winner = 1;
            else if (bv)  winner = 2;
        end
        exp_we = (model_q.size() != 0) && drain;
        head.addr = '0; head.data = '0;
        if (model_q.size() != 0) head = model_q[0];
        exp_p1 = 1'b0; exp_p2 = 1'b0;
        foreach (model_q[i]) begin
            if (c1 != 0 && model_q[i].addr == c1) exp_p1 = 1'b1;
            if (c2 != 0 && model_q[i].addr == c2) exp_p2 = 1'b1;
        end
        chk("a_ready", 32'(bus.out_a_ready), 32'(winner == 1));
        chk("b_ready", 32'(bus.out_b_ready), 32'(winner == 2));
        chk("we",      32'(bus.out_we),      32'(exp_we));
        chk("wr_addr", 32'(bus.out_wr_addr), 32'(head.addr));
        chk("wr_data", 32'(bus.out_wr_data), 32'(head.data));
        chk("pend1",   32'(bus.out_pend1),   32'(exp_p1));
        chk("pend2",   32'(bus.out_pend2),   32'(exp_p2));
        chk("count",   32'(bus.out_count),   32'(model_q.size()));
        @(posedge clk);
        if (exp_we) void'(model_q.pop_front());
        if (winner == 1 && aa != 0) model_q.push_back('{addr: aa, data: ad});
        if (winner == 2 && ba != 0) model_q.push_back('{addr: ba, data: bd});
        if (av && bv && winner != 0) last_contention_winner_a = (winner == 1);
        #1;
    endtask

    task automatic idle(input bit drain);
        cycle(0, 0, 0, 0, 0, 0, drain, 0, 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_a_valid = 0; bus.in_a_addr = 0; bus.in_a_data = 0;
        bus.in_b_valid = 0; bus.in_b_addr = 0; bus.in_b_data = 0;
        bus.in_drain_en = 0; bus.in_chk_addr1 = 0; bus.in_chk_addr2 = 0;
        model_reset();
        @(posedge clk);
        #1;
        pulse_reset();

        // Single write from A, drained on the following cycle.
        cycle(1, 1, 8'h5A, 0, 0, 0, 1, 0, 0);
        idle(1);
        idle(1);

        // Contention for four cycles, then a full-queue refusal, then ordered drain.
        for (int i = 0; i < 4; i++)
            cycle(1, 2'(1 + (i % 3)), 8'(8'hA0 + i), 1, 2'(1 + ((i + 1) % 3)), 8'(8'hB0 + i), 0, 1, 2);
        cycle(1, 1, 8'hEE, 1, 2, 8'hDD, 0, 3, 1);
        for (int i = 0; i < 5; i++) idle(1);

        // Write to r0 is acknowledged but dropped.
        cycle(0, 0, 0, 1, 0, 8'hFF, 1, 0, 0);
        idle(1);
        idle(1);

        // Hazard lookup on r3 while it is queued and after it drains.
        cycle(1, 3, 8'h33, 0, 0, 0, 0, 3, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 3, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 3, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 3, 0);

        // Full queue with a drain and A waiting, then A accepted.
        for (int i = 0; i < 4; i++) cycle(1, 2'(1 + (i % 3)), 8'(8'h10 + i), 0, 0, 0, 0, 0, 0);
        cycle(1, 2, 8'h77, 0, 0, 0, 1, 2, 0);
        cycle(1, 2, 8'h77, 0, 0, 0, 0, 2, 0);
        idle(0);

        // Reset with entries queued: none of them may reach the write port.
        pulse_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 2'(1 + i), 8'(8'hC0 + i), 0, 0, 0);
        pulse_reset();
        for (int i = 0; i < 3; i++) idle(1);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 79) == 0) pulse_reset();
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 6; i++) idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
